// File: rtl/ysyx_25020047_lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory port.
// Accepts one op, issues a single bus request, waits for the response
// (with timeout), aligns byte lanes, and holds the result until writeback.
module ysyx_25020047_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e           state_q;
  logic [1:0]       lane_q;   // byte offset of the access within the word
  logic             word_q;   // 1 = word access, 0 = byte access
  logic             read_q;   // op is a load
  logic [CNT_W-1:0] cnt_q;    // cycles spent in RESP without a response

  logic             size_word;
  logic             dec_err;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_hit;
  logic [31:0]      load_data;

  assign in_ready  = (state_q == IDLE);
  assign size_word = (in_size == 2'b10);

  // Illegal combinations are rejected before touching the bus.
  assign dec_err = (in_read & in_write)
                 | (in_size[0] == 1'b1)
                 | (size_word & (in_addr[1:0] != 2'b00));

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  // Select the load result: full word, or the addressed byte zero-extended.
  always_comb begin
    load_data = mem_resp_rdata;
    if (!word_q) begin
      case (lane_q)
        2'd0:    load_data = {24'h0, mem_resp_rdata[7:0]};
        2'd1:    load_data = {24'h0, mem_resp_rdata[15:8]};
        2'd2:    load_data = {24'h0, mem_resp_rdata[23:16]};
        default: load_data = {24'h0, mem_resp_rdata[31:24]};
      endcase
    end
  end

  // Sequencer FSM; all bus and result outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lane_q         <= 2'b00;
      word_q         <= 1'b0;
      read_q         <= 1'b0;
      cnt_q          <= '0;
      out_valid      <= 1'b0;
      out_rdata      <= 32'h0;
      out_err        <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= 32'h0;
      mem_req_wen    <= 1'b0;
      mem_req_wdata  <= 32'h0;
      mem_req_wstrb  <= 4'h0;
      mem_resp_ready <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            lane_q <= in_addr[1:0];
            word_q <= size_word;
            read_q <= in_read;
            if (dec_err) begin
              state_q   <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= 32'h0;
            end else if (!in_read && !in_write) begin
              state_q   <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_rdata <= 32'h0;
            end else begin
              state_q       <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wen   <= in_write;
              if (in_write) begin
                mem_req_wstrb <= size_word ? 4'hF : (4'b0001 << in_addr[1:0]);
                mem_req_wdata <= size_word ? in_wdata : {4{in_wdata[7:0]}};
              end else begin
                mem_req_wstrb <= 4'h0;
                mem_req_wdata <= 32'h0;
              end
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_q        <= RESP;
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            cnt_q          <= '0;
          end
        end
        RESP: begin
          // A response in the limit cycle takes priority over the timeout.
          if (mem_resp_valid) begin
            state_q        <= DONE;
            mem_resp_ready <= 1'b0;
            out_valid      <= 1'b1;
            out_err        <= mem_resp_err;
            out_rdata      <= (mem_resp_err || !read_q) ? 32'h0 : load_data;
          end else if (timeout_hit) begin
            state_q        <= DONE;
            mem_resp_ready <= 1'b0;
            out_valid      <= 1'b1;
            out_err        <= 1'b1;
            out_rdata      <= 32'h0;
            cnt_q          <= cnt_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= 32'h0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu_ctrl.sv
// Directed self-checking bench for the load/store sequencer (timeout = 4).
module tb_ysyx_25020047_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_read, in_write;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25020047_lsu_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_read(in_read), .in_write(in_write),
    .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, out_err, out_rdata, mem_req_valid, mem_req_wen, mem_req_addr,
         mem_req_wstrb, mem_req_wdata, mem_resp_ready, in_ready} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b e=%b rd=%h rv=%b addr=%h strb=%b rr=%b ir=%b exp all 0, in_ready 1",
               out_valid, out_err, out_rdata, mem_req_valid, mem_req_addr, mem_req_wstrb,
               mem_resp_ready, in_ready);
    end
    $display("reset: checked idle outputs");
  endtask

  // Load with zero-wait request and response; result appears 3 cycles after accept.
  task automatic test_load(input string name, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_rdata);
    in_valid = 1; in_read = 1; in_write = 0; in_size = size; in_addr = addr; in_wdata = 32'h0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = rdata; mem_resp_err = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready got %b exp 1", name, in_ready);
    end
    step();
    in_valid = 0; in_read = 0;
    checks++;
    if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, out_valid, in_ready} !==
        {1'b1, 1'b0, exp_addr, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_req got v=%b wen=%b addr=%h strb=%b ov=%b ir=%b exp v=1 wen=0 addr=%h strb=0000 ov=0 ir=0",
               name, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, out_valid, in_ready, exp_addr);
    end
    step();
    checks++;
    if ({mem_req_valid, mem_resp_ready, out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL %s_resp_phase got rv=%b rr=%b ov=%b exp 0 1 0", name, mem_req_valid, mem_resp_ready, out_valid);
    end
    step();
    mem_req_ready = 0; mem_resp_valid = 0;
    checks++;
    if ({out_valid, out_err, out_rdata, in_ready, mem_resp_ready} !== {1'b1, 1'b0, exp_rdata, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_result got v=%b e=%b rd=%h ir=%b rr=%b exp v=1 e=0 rd=%h ir=0 rr=0",
               name, out_valid, out_err, out_rdata, in_ready, mem_resp_ready, exp_rdata);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s_release got ov=%b ir=%b exp 0 1", name, out_valid, in_ready);
    end
    $display("%s: addr=%h rdata=%h out=%h", name, addr, rdata, out_rdata);
  endtask

  // Byte store with the bus stalling the request for three cycles.
  task automatic test_sb_stall();
    in_valid = 1; in_read = 0; in_write = 1; in_size = 2'b00; in_addr = 32'h80000002;
    in_wdata = 32'h123456EF; mem_req_ready = 0; mem_resp_valid = 0;
    step();
    in_valid = 0; in_write = 0; in_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata} !==
          {1'b1, 1'b1, 32'h80000000, 4'b0100, 32'hEFEFEFEF}) begin
        errors++;
        $display("FAIL sb_hold%0d got v=%b wen=%b addr=%h strb=%b wd=%h exp 1 1 80000000 0100 efefefef",
                 i, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata);
      end
      step();
    end
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    checks++;
    if ({mem_req_valid, mem_resp_ready} !== 2'b01) begin
      errors++; $display("FAIL sb_handshake got rv=%b rr=%b exp 0 1", mem_req_valid, mem_resp_ready);
    end
    mem_resp_valid = 1; mem_resp_rdata = 32'hFFFFFFFF; mem_resp_err = 0;
    step();
    mem_resp_valid = 0;
    checks++;
    if ({out_valid, out_err, out_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL sb_result got v=%b e=%b rd=%h exp 1 0 00000000", out_valid, out_err, out_rdata);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    $display("sb: addr=80000002 wdata=123456ef stalled 3 cycles");
  endtask

  // Decode errors complete one cycle after accept without any bus request.
  task automatic test_decode_err(input string name, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic [31:0] addr);
    in_valid = 1; in_read = rd; in_write = wr; in_size = size; in_addr = addr;
    mem_req_ready = 1; mem_resp_valid = 0;
    step();
    in_valid = 0; in_read = 0; in_write = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, out_err, out_rdata, mem_req_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL %s_c%0d got v=%b e=%b rd=%h rv=%b exp 1 1 00000000 0",
                 name, i, out_valid, out_err, out_rdata, mem_req_valid);
      end
      step();
    end
    mem_req_ready = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    $display("%s: decode error reported", name);
  endtask

  // A bus error response reports out_err with zero data.
  task automatic test_resp_err();
    in_valid = 1; in_read = 1; in_write = 0; in_size = 2'b10; in_addr = 32'h80000010;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h55667788; mem_resp_err = 1;
    step(); in_valid = 0; in_read = 0;
    step(); step();
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
    checks++;
    if ({out_valid, out_err, out_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL resp_err got v=%b e=%b rd=%h exp 1 1 00000000", out_valid, out_err, out_rdata);
    end
    out_ready = 1; step(); out_ready = 0;
    $display("resp_err: bus error propagated");
  endtask

  // No response: after 4 RESP cycles the op aborts; later stray responses are refused.
  task automatic test_timeout();
    in_valid = 1; in_read = 1; in_write = 0; in_size = 2'b10; in_addr = 32'h80000020;
    mem_req_ready = 1; mem_resp_valid = 0;
    step(); in_valid = 0; in_read = 0;
    step(); mem_req_ready = 0;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if ({mem_resp_ready, out_valid} !== 2'b10) begin
        errors++; $display("FAIL timeout_wait%0d got rr=%b ov=%b exp 1 0", i, mem_resp_ready, out_valid);
      end
    end
    step();
    checks++;
    if ({out_valid, out_err, out_rdata, mem_resp_ready} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_result got v=%b e=%b rd=%h rr=%b exp 1 1 00000000 0", out_valid, out_err, out_rdata, mem_resp_ready);
    end
    out_ready = 1; step(); out_ready = 0;
    mem_resp_valid = 1; mem_resp_rdata = 32'h12345678;
    checks++;
    if (mem_resp_ready !== 1'b0) begin
      errors++; $display("FAIL stray_ready got %b exp 0", mem_resp_ready);
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL stray_ignored got ov=%b ir=%b exp 0 1", out_valid, in_ready);
    end
    mem_resp_valid = 0;
    $display("timeout: aborted after 4 RESP cycles, stray response refused");
  endtask

  // Response arriving in the 4th (limit) RESP cycle wins over the timeout.
  task automatic test_timeout_edge();
    in_valid = 1; in_read = 1; in_write = 0; in_size = 2'b00; in_addr = 32'h80000031;
    mem_req_ready = 1; mem_resp_valid = 0;
    step(); in_valid = 0; in_read = 0;
    step(); mem_req_ready = 0;
    step(); step(); step();
    mem_resp_valid = 1; mem_resp_rdata = 32'h11229A44; mem_resp_err = 0;
    step();
    mem_resp_valid = 0;
    checks++;
    if ({out_valid, out_err, out_rdata} !== {1'b1, 1'b0, 32'h0000009A}) begin
      errors++; $display("FAIL limit_resp got v=%b e=%b rd=%h exp 1 0 0000009a", out_valid, out_err, out_rdata);
    end
    out_ready = 1; step(); out_ready = 0;
    $display("timeout_edge: late response accepted rd=%h", out_rdata);
  endtask

  // Reset asserted while waiting for a response clears outputs immediately.
  task automatic test_reset_mid();
    in_valid = 1; in_read = 1; in_write = 0; in_size = 2'b10; in_addr = 32'h80000040;
    mem_req_ready = 1; mem_resp_valid = 0;
    step(); in_valid = 0; in_read = 0;
    step(); mem_req_ready = 0;
    checks++;
    if (mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL mid_in_resp got rr=%b exp 1", mem_resp_ready);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, out_err, out_rdata, mem_req_valid, mem_req_addr, mem_resp_ready, in_ready} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset got v=%b e=%b rd=%h rv=%b addr=%h rr=%b ir=%b exp 0 0 0 0 0 0 1",
               out_valid, out_err, out_rdata, mem_req_valid, mem_req_addr, mem_resp_ready, in_ready);
    end
    step();
    rst_n = 1;
    $display("reset_mid: outputs cleared asynchronously");
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_read = 0; in_write = 0; in_size = 2'b00; in_addr = 32'h0;
    in_wdata = 32'h0; out_ready = 0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_rdata = 32'h0; mem_resp_err = 0;
    step(); step();
    test_reset();
    rst_n = 1;
    step();
    test_load("lw", 2'b10, 32'h80000004, 32'hDEADBEEF, 32'h80000004, 32'hDEADBEEF);
    test_load("lbu", 2'b00, 32'h80000007, 32'hA1B2C3D4, 32'h80000004, 32'h000000A1);
    test_load("lbu0", 2'b00, 32'h80000008, 32'hA1B2C3D4, 32'h80000008, 32'h000000D4);
    test_sb_stall();
    test_decode_err("misaligned_lw", 1'b1, 1'b0, 2'b10, 32'h80000001);
    test_decode_err("read_write", 1'b1, 1'b1, 2'b10, 32'h80000000);
    test_decode_err("bad_size", 1'b1, 1'b0, 2'b01, 32'h80000000);
    test_resp_err();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_load("lw_after_reset", 2'b10, 32'h80000004, 32'hCAFEF00D, 32'h80000004, 32'hCAFEF00D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
